// File: rtl/mold_pkg.sv
// Shared definitions for the MoldUDP64 packet builder: widths, header
// byte offsets, FSM states and the byte-count to thermometer-mask helper.
package mold_pkg;

  localparam int AXI_DATA_W = 64;
  localparam int AXI_KEEP_W = 8;
  localparam int ML_W       = 16;
  localparam int SID_W      = 80;
  localparam int SEQ_W      = 64;
  localparam int MC_W       = 16;

  // Residual holds at most one byte less than a full beat.
  localparam int RES_W      = AXI_DATA_W - 8;

  localparam int SID_OFF    = 0;
  localparam int SEQ_OFF    = 10;
  localparam int CNT_OFF    = 18;
  localparam int HDR_LEN    = 20;
  localparam int HDR_W      = HDR_LEN * 8;
  localparam int LEN_PFX    = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_FLUSH = 3'd4
  } state_e;

  // Thermometer mask with the low n lanes set (n = 0..8).
  function automatic logic [AXI_KEEP_W-1:0] len_to_mask(input logic [3:0] n);
    logic [AXI_KEEP_W-1:0] m;
    m = {AXI_KEEP_W{1'b0}};
    for (int i = 0; i < AXI_KEEP_W; i++) begin
      m[i] = (4'(i) < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/mold_tx_pack.sv
// Byte-merge shifter: appends n new bytes behind the residual at offset
// fill; a full beat drops out once eight bytes have accumulated.
module mold_tx_pack
  import mold_pkg::*;
(
  input  logic [RES_W-1:0]      res_i,
  input  logic [2:0]            fill_i,
  input  logic [AXI_DATA_W-1:0] bytes_i,
  input  logic [3:0]            n_i,
  output logic [AXI_DATA_W-1:0] beat_o,
  output logic                  beat_v_o,
  output logic [RES_W-1:0]      res_o,
  output logic [2:0]            fill_o
);

  localparam int CAT_W = RES_W + AXI_DATA_W;

  logic [AXI_KEEP_W-1:0] lane_mask_s;
  logic [AXI_DATA_W-1:0] new_s;
  logic [CAT_W-1:0]      cat_s;
  logic [3:0]            total_s;

  // Zero unused input lanes, merge behind the residual and split off a full beat.
  always_comb begin
    lane_mask_s = len_to_mask(n_i);
    new_s       = {AXI_DATA_W{1'b0}};
    for (int i = 0; i < AXI_KEEP_W; i++) begin
      new_s[8*i +: 8] = bytes_i[8*i +: 8] & {8{lane_mask_s[i]}};
    end
    cat_s   = {{AXI_DATA_W{1'b0}}, res_i} | ({{RES_W{1'b0}}, new_s} << {fill_i, 3'b000});
    total_s = {1'b0, fill_i} + n_i;
    if (total_s >= 4'd8) begin
      beat_v_o = 1'b1;
      beat_o   = cat_s[AXI_DATA_W-1:0];
      res_o    = cat_s[CAT_W-1:AXI_DATA_W];
      fill_o   = 3'(total_s - 4'd8);
    end else begin
      beat_v_o = 1'b0;
      beat_o   = {AXI_DATA_W{1'b0}};
      res_o    = cat_s[RES_W-1:0];
      fill_o   = total_s[2:0];
    end
  end

endmodule

// File: rtl/mold_tx.sv
// MoldUDP64 packet builder: header, then length-prefixed messages, byte
// packed onto a 64-bit AXI stream with a registered output stage.
module mold_tx
  import mold_pkg::*;
(
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [SID_W-1:0]      sid_i,
  input  logic                  seq_init_v_i,
  input  logic [SEQ_W-1:0]      seq_init_i,
  input  logic                  pkt_v_i,
  input  logic [MC_W-1:0]       pkt_msg_cnt_i,
  output logic                  pkt_ready_o,
  input  logic                  mold_msg_v_i,
  input  logic                  mold_msg_start_i,
  input  logic [ML_W-1:0]       mold_msg_len_i,
  input  logic [AXI_KEEP_W-1:0] mold_msg_mask_i,
  input  logic [AXI_DATA_W-1:0] mold_msg_data_i,
  output logic                  mold_msg_ready_o,
  output logic                  udp_axis_tvalid_o,
  output logic [AXI_KEEP_W-1:0] udp_axis_tkeep_o,
  output logic [AXI_DATA_W-1:0] udp_axis_tdata_o,
  output logic                  udp_axis_tlast_o,
  input  logic                  udp_axis_tready_i,
  output logic                  err_o
);

  state_e                state_q, state_d;
  logic [1:0]            hdr_idx_q, hdr_idx_d;
  logic [MC_W-1:0]       cnt_q, cnt_d, pkt_cnt_q, pkt_cnt_d;
  logic [ML_W-1:0]       rem_q, rem_d;
  logic                  first_q, first_d;
  logic [SEQ_W-1:0]      seq_q, seq_d, seq_snap_q, seq_snap_d;
  logic [RES_W-1:0]      res_q, res_d;
  logic [2:0]            fill_q, fill_d;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [AXI_KEEP_W-1:0] tkeep_q, tkeep_d;
  logic [AXI_DATA_W-1:0] tdata_q, tdata_d;
  logic                  err_q, err_d;

  logic                  adv_s, last_acc_s, commit_s, last_s;
  logic                  pkt_ready_s, msg_ready_s, start_err_s, mask_err_s;
  logic [HDR_W-1:0]      hdr_s;
  logic [AXI_DATA_W-1:0] push_bytes_s, pk_beat_s;
  logic [3:0]            push_n_s;
  logic                  pk_v_s;
  logic [RES_W-1:0]      pk_res_s;
  logic [2:0]            pk_fill_s;

  // The engine may step when the output register is empty or being drained.
  assign adv_s      = ~tvalid_q | udp_axis_tready_i;
  assign last_acc_s = tvalid_q & tlast_q & udp_axis_tready_i;

  // Assemble the 20-byte header, least-significant byte first per field.
  always_comb begin
    hdr_s = {HDR_W{1'b0}};
    hdr_s[SID_OFF*8 +: SID_W] = sid_i;
    hdr_s[SEQ_OFF*8 +: SEQ_W] = seq_snap_q;
    hdr_s[CNT_OFF*8 +: MC_W]  = pkt_cnt_q;
  end

  // Select the bytes and byte count fed to the packer in the current state.
  always_comb begin
    push_bytes_s = {AXI_DATA_W{1'b0}};
    push_n_s     = 4'd0;
    case (state_q)
      S_HDR: begin
        case (hdr_idx_q)
          2'd0: begin
            push_bytes_s = hdr_s[63:0];
            push_n_s     = 4'd8;
          end
          2'd1: begin
            push_bytes_s = hdr_s[127:64];
            push_n_s     = 4'd8;
          end
          default: begin
            push_bytes_s = {32'h0000_0000, hdr_s[159:128]};
            push_n_s     = 4'd4;
          end
        endcase
      end
      S_LEN: begin
        push_bytes_s = {48'h0000_0000_0000, mold_msg_len_i};
        push_n_s     = 4'(LEN_PFX);
      end
      S_DATA: begin
        push_bytes_s = mold_msg_data_i;
        push_n_s     = (rem_q >= 16'd8) ? 4'd8 : rem_q[3:0];
      end
      default: begin
        push_bytes_s = {AXI_DATA_W{1'b0}};
        push_n_s     = 4'd0;
      end
    endcase
  end

  mold_tx_pack u_pack (
    .res_i    (res_q),
    .fill_i   (fill_q),
    .bytes_i  (push_bytes_s),
    .n_i      (push_n_s),
    .beat_o   (pk_beat_s),
    .beat_v_o (pk_v_s),
    .res_o    (pk_res_s),
    .fill_o   (pk_fill_s)
  );

  // Next-state, sequence bookkeeping, error detection and output-register load.
  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    cnt_d       = cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    rem_d       = rem_q;
    first_d     = first_q;
    seq_snap_d  = seq_snap_q;
    res_d       = res_q;
    fill_d      = fill_q;
    tvalid_d    = tvalid_q & ~udp_axis_tready_i;
    tlast_d     = tlast_q;
    tkeep_d     = tkeep_q;
    tdata_d     = tdata_q;
    commit_s    = 1'b0;
    last_s      = 1'b0;
    pkt_ready_s = 1'b0;
    msg_ready_s = 1'b0;
    start_err_s = 1'b0;
    mask_err_s  = 1'b0;

    // A reload from seq_init wins over the end-of-packet increment.
    if (state_q == S_IDLE && seq_init_v_i) begin
      seq_d = seq_init_i;
    end else if (last_acc_s) begin
      seq_d = seq_q + SEQ_W'(pkt_cnt_q);
    end else begin
      seq_d = seq_q;
    end

    case (state_q)
      S_IDLE: begin
        // Hold off a new command while the previous final beat is still stalled,
        // so the header snapshot always sees the updated sequence number.
        pkt_ready_s = ~(tvalid_q & tlast_q & ~udp_axis_tready_i);
        if (pkt_v_i && pkt_ready_s) begin
          cnt_d      = pkt_msg_cnt_i;
          pkt_cnt_d  = pkt_msg_cnt_i;
          seq_snap_d = seq_d;
          hdr_idx_d  = 2'd0;
          state_d    = S_HDR;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_HDR: begin
        if (adv_s) begin
          commit_s = 1'b1;
          if (hdr_idx_q == 2'd2) begin
            state_d = (cnt_q != {MC_W{1'b0}}) ? S_LEN : S_FLUSH;
          end else begin
            hdr_idx_d = hdr_idx_q + 2'd1;
          end
        end else begin
          state_d = S_HDR;
        end
      end
      S_LEN: begin
        // The start beat is only peeked here; DATA consumes it.
        if (adv_s && mold_msg_v_i) begin
          commit_s    = 1'b1;
          rem_d       = mold_msg_len_i;
          first_d     = 1'b1;
          start_err_s = ~mold_msg_start_i;
          state_d     = S_DATA;
        end else begin
          state_d = S_LEN;
        end
      end
      S_DATA: begin
        msg_ready_s = adv_s;
        if (adv_s && mold_msg_v_i) begin
          commit_s    = 1'b1;
          first_d     = 1'b0;
          start_err_s = mold_msg_start_i & ~first_q;
          if (rem_q <= 16'd8) begin
            mask_err_s = (mold_msg_mask_i != len_to_mask(rem_q[3:0]));
            rem_d      = {ML_W{1'b0}};
            cnt_d      = cnt_q - 16'd1;
            if (cnt_q != 16'd1) begin
              state_d = S_LEN;
            end else if (pk_fill_s != 3'd0) begin
              state_d = S_FLUSH;
            end else begin
              state_d = S_IDLE;
              last_s  = 1'b1;
            end
          end else begin
            rem_d = rem_q - 16'd8;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_FLUSH: begin
        if (adv_s) begin
          tvalid_d = 1'b1;
          tdata_d  = {8'h00, res_q};
          tkeep_d  = len_to_mask({1'b0, fill_q});
          tlast_d  = 1'b1;
          res_d    = {RES_W{1'b0}};
          fill_d   = 3'd0;
          state_d  = S_IDLE;
        end else begin
          state_d = S_FLUSH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (commit_s) begin
      res_d  = pk_res_s;
      fill_d = pk_fill_s;
      if (pk_v_s) begin
        tvalid_d = 1'b1;
        tdata_d  = pk_beat_s;
        tkeep_d  = 8'hFF;
        tlast_d  = last_s;
      end else begin
        tvalid_d = tvalid_d;
      end
    end else begin
      res_d = res_d;
    end

    err_d = err_q | start_err_s | mask_err_s;
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      hdr_idx_q  <= 2'd0;
      cnt_q      <= {MC_W{1'b0}};
      pkt_cnt_q  <= {MC_W{1'b0}};
      rem_q      <= {ML_W{1'b0}};
      first_q    <= 1'b0;
      seq_q      <= 64'd1;
      seq_snap_q <= {SEQ_W{1'b0}};
      res_q      <= {RES_W{1'b0}};
      fill_q     <= 3'd0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tkeep_q    <= {AXI_KEEP_W{1'b0}};
      tdata_q    <= {AXI_DATA_W{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_idx_q  <= hdr_idx_d;
      cnt_q      <= cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      rem_q      <= rem_d;
      first_q    <= first_d;
      seq_q      <= seq_d;
      seq_snap_q <= seq_snap_d;
      res_q      <= res_d;
      fill_q     <= fill_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tkeep_q    <= tkeep_d;
      tdata_q    <= tdata_d;
      err_q      <= err_d;
    end
  end

  assign pkt_ready_o       = pkt_ready_s;
  assign mold_msg_ready_o  = msg_ready_s;
  assign udp_axis_tvalid_o = tvalid_q;
  assign udp_axis_tkeep_o  = tkeep_q;
  assign udp_axis_tdata_o  = tdata_q;
  assign udp_axis_tlast_o  = tlast_q;
  assign err_o             = err_q;

endmodule

// File: doc/mold_tx.md
Name: mold_tx

Overview:
- MoldUDP64 packet builder: the transmit-side counterpart of the MoldUDP64 receive parser.
- Accepts a per-packet command carrying the message count, then a stream of Mold messages in the parser's output format.
- Emits a byte-packed AXI stream of the UDP payload: 20-byte header, then one 2-byte length prefix plus payload per message, at arbitrary byte alignment.
- Sits between the message source and the UDP/Ethernet TX stack.

Parameters:
- AXI_DATA_W, 64, AXI data width in bits (8 byte lanes).
- AXI_KEEP_W, 8, tkeep width.
- ML_W, 16, message length field width.
- SID_W, 80, session id width.
- SEQ_W, 64, sequence number width.
- MC_W, 16, message count width.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- sid_i  in  SID_W  session id, static while a packet is in flight
- seq_init_v_i  in  1  load seq_init_i; honoured only in IDLE
- seq_init_i  in  SEQ_W  new next sequence number
- pkt_v_i  in  1  packet command valid
- pkt_msg_cnt_i  in  MC_W  number of messages in the packet (0 = heartbeat)
- pkt_ready_o  out  1  command accepted when pkt_v_i & pkt_ready_o
- mold_msg_v_i  in  1  message beat valid
- mold_msg_start_i  in  1  first beat of a message
- mold_msg_len_i  in  ML_W  message length in bytes; sampled on the start beat
- mold_msg_mask_i  in  AXI_KEEP_W  thermometer byte mask; all 1s except on the last beat
- mold_msg_data_i  in  AXI_DATA_W  message bytes; byte i is lane i (bits 8i+7:8i)
- mold_msg_ready_o  out  1  beat accepted when v & ready
- udp_axis_tvalid_o  out  1
- udp_axis_tkeep_o  out  AXI_KEEP_W
- udp_axis_tdata_o  out  AXI_DATA_W
- udp_axis_tlast_o  out  1
- udp_axis_tready_i  in  1
- err_o  out  1  sticky protocol error

Behaviour:
- Reset: single clock; reset is asynchronous and active-low, applied on nreset low. State IDLE, seq_q=1, residual fill=0. Reset values: tvalid/tlast/tkeep/tdata=0, err_o=0, mold_msg_ready_o=0, pkt_ready_o=1.
- Byte order: wire byte 0 = lane 0 of the first beat. Multi-byte fields are least-significant byte first.
- Header layout: sid bytes 0-9, seq bytes 10-17, msg_cnt bytes 18-19. Each message is len (2 bytes) followed by len data bytes.
- Packing engine:
  - Residual register holds up to 7 bytes plus a fill count (0..7).
  - Each step appends N new bytes at offset fill.
  - If fill+N >= 8, the low 8 bytes go to the output register and the rest become the new residual.
  - Pushes per step: header 8/8/4, length 2, data min(remaining, 8).
- Output register: tvalid holds until udp_axis_tready_i. tdata/tkeep/tlast are stable while tvalid & ~tready. The engine advances only when the output register is empty or being accepted this cycle.
- FSM:
  - IDLE: pkt_ready_o=1. On accept, latch cnt and snapshot seq_q; go HDR.
  - HDR: 3 steps (header bytes 0-7, 8-15, then 16-19 leaving fill=4). Then go LEN if cnt != 0, else FLUSH.
  - LEN: push len from mold_msg_len_i; requires mold_msg_v_i & mold_msg_start_i. The beat is not consumed; mold_msg_ready_o=0. Latch rem=len. Go DATA.
  - DATA: mold_msg_ready_o=1 when the engine can advance. Push bytes; rem -= min(rem, 8).
    - If rem <= 8: message done, cnt -= 1.
    - Then go LEN if cnt != 0. Otherwise go FLUSH if fill != 0, else IDLE.
  - FLUSH: emit residual with tkeep = thermometer(fill), tlast=1, fill=0; go IDLE.
- tlast: set on the beat carrying the final packet byte. With exact alignment this is the last full beat (keep=FF) and FLUSH is skipped.
- Sequence number: seq_q += packet msg_cnt when the packet's last beat is accepted. Wraps modulo 2^SEQ_W. seq_init_v_i outside IDLE is ignored.
- Latency and throughput: first header beat tvalid one cycle after command accept. One bubble per message for the length prefix.
- Input assumptions: msg_len >= 1. Mask is not used for byte counting.
- err_o is set (sticky until reset) on:
  - mold_msg_start_i=0 in LEN, or mold_msg_start_i=1 on a non-first DATA beat;
  - a last-beat mask inconsistent with rem.
  After an error, counting proceeds using len.
- Reset mid-packet: everything returns to reset values immediately. No partial tlast is generated.

Decomposition:
- Shared package mold_pkg: header byte offsets (SID_OFF=0, SEQ_OFF=10, CNT_OFF=18, HDR_LEN=20), length-prefix size 2, FSM state enum, widths.
- One sub-module: mold_tx_pack, the residual/byte-merge shifter taking (bytes, N, fill) and returning the out beat, out-valid and new residual. Reuse len_to_mask for tkeep.

Test Plan:
- Heartbeat: seq_init=1, sid=0x0A0908..01, cnt=0 -> 3 beats, keep FF,FF,0F; tlast on beat 2; beat2 lanes 2-3 = 00 00; seq_q stays 1.
- One message, len=5, data bytes D0..D4 -> 4 beats, keep FF,FF,FF,07; beat2 lanes 4-5 = 05 00, lanes 6-7 = D0 D1; beat3 lanes 0-2 = D2..D4, tlast; seq_q=2.
- Two messages, len 2 then 12 -> 38 bytes, 5 beats, last keep 3F; one bubble each before message 1 and message 2; seq_q += 2.
- Exact alignment, len=10 -> 32 bytes, 4 full beats, tlast on beat 3 with keep FF; no extra beat; pkt_ready_o high the next cycle.
- Random udp_axis_tready_i low 50% -> output fields stable while stalled; byte stream identical to the no-stall run; mold_msg_ready_o low while stalled.
- nreset low during DATA -> tvalid=0 asynchronously, seq_q=1; the next packet is correct. Missing start in LEN -> err_o=1 sticky.
